// File: rtl/game_flow_pkg.sv
// Shared types and constants for the Gold Miner screen sequencer.
package game_flow_pkg;

  // Screen sequence states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    LEVEL_END = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int LEVEL_W = 3;
  localparam int SEC_W   = 7;

  // Colour shown where no drawing layer requests a pixel
  localparam logic [7:0] DEFAULT_BG_RGB = 8'h00;

endpackage

// File: rtl/layer_priority_mux.sv
// Registered priority merge of the per-layer drawing requests.
// Layer 0 has the highest priority; one clock of latency.
module layer_priority_mux
  import game_flow_pkg::*;
#(
  parameter int         NUM_LAYERS = 4,
  parameter logic [7:0] BG_RGB     = DEFAULT_BG_RGB
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [NUM_LAYERS-1:0]   layerDrawReq,
  input  logic [NUM_LAYERS*8-1:0] layerRGB,
  output logic                    drawingRequest,
  output logic [7:0]              RGBout
);

  logic [7:0] layer_rgb [NUM_LAYERS];
  logic       req_next;
  logic [7:0] rgb_next;
  logic       req_reg;
  logic [7:0] rgb_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_slice
      assign layer_rgb[gi] = layerRGB[8*gi +: 8];
    end
  endgenerate

  // Walk from lowest to highest priority so the lowest requesting index wins
  always_comb begin
    req_next = 1'b0;
    rgb_next = BG_RGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layerDrawReq[i]) begin
        req_next = 1'b1;
        rgb_next = layer_rgb[i];
      end
    end
  end

  // Output register towards the VGA stage
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      req_reg <= 1'b0;
      rgb_reg <= BG_RGB;
    end else begin
      req_reg <= req_next;
      rgb_reg <= rgb_next;
    end
  end

  assign drawingRequest = req_reg;
  assign RGBout         = rgb_reg;

endmodule

// File: rtl/game_flow_controller.sv
// Gold Miner screen sequencer: IDLE -> PLAY -> LEVEL_END -> PLAY/GAME_OVER,
// level timer from startOfFrame, and the merged drawing output.
// Optional build macro GAME_FLOW_PAUSE_EN adds pauseKey/paused.
module game_flow_controller
  import game_flow_pkg::*;
#(
  parameter int         FRAMES_PER_SEC = 60,
  parameter int         LEVEL_SECONDS  = 60,
  parameter int         SHOW_FRAMES    = 120,
  parameter int         MAX_LEVEL      = 5,
  parameter int         NUM_LAYERS     = 4,
  parameter logic [7:0] BG_RGB         = DEFAULT_BG_RGB
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    keyStart,
  input  logic                    scoreReached,
  input  logic [NUM_LAYERS-1:0]   layerDrawReq,
  input  logic [NUM_LAYERS*8-1:0] layerRGB,
`ifdef GAME_FLOW_PAUSE_EN
  input  logic                    pauseKey,
  output logic                    paused,
`endif
  output logic                    startScreenEn,
  output logic                    gameLoopEn,
  output logic                    levelEndEn,
  output logic                    gameOverEn,
  output logic [LEVEL_W-1:0]      level,
  output logic [SEC_W-1:0]        secondsLeft,
  output logic                    levelStartPulse,
  output logic                    drawingRequest,
  output logic [7:0]              RGBout
);

  // One counter serves both the timer seconds and the level-end hold time
  localparam int CNT_MAX = (FRAMES_PER_SEC > SHOW_FRAMES) ? FRAMES_PER_SEC : SHOW_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t             state_reg, state_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic [SEC_W-1:0]   sec_reg, sec_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               pulse_reg, pulse_next;
  logic [3:0]         en_reg, en_next;     // {start, loop, levelEnd, gameOver}
  logic               key_d_reg;
  logic               key_edge;
  logic               frame_tick;
  logic               paused_reg, paused_next;

  assign key_edge = keyStart & ~key_d_reg;

`ifdef GAME_FLOW_PAUSE_EN
  logic pause_d_reg;
  logic pause_edge;
  assign pause_edge = pauseKey & ~pause_d_reg;
  assign frame_tick = startOfFrame & ~paused_reg;
  assign paused     = paused_reg;

  // Pause key history for edge detection
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) pause_d_reg <= 1'b0;
    else         pause_d_reg <= pauseKey;
  end
`else
  assign frame_tick = startOfFrame;
`endif

  // Next-state, timer and level bookkeeping
  always_comb begin
    state_next  = state_reg;
    level_next  = level_reg;
    sec_next    = sec_reg;
    cnt_next    = cnt_reg;
    pulse_next  = 1'b0;
    paused_next = paused_reg;
    case (state_reg)
      IDLE: begin
        if (key_edge) begin
          state_next = PLAY;
          level_next = LEVEL_W'(1);
          sec_next   = SEC_W'(LEVEL_SECONDS);
          cnt_next   = '0;
          pulse_next = 1'b1;
        end
      end
      PLAY: begin
`ifdef GAME_FLOW_PAUSE_EN
        if (pause_edge) paused_next = ~paused_reg;
`endif
        if (frame_tick) begin
          if (cnt_reg == CNT_W'(FRAMES_PER_SEC - 1)) begin
            cnt_next = '0;
            if (sec_reg != '0) sec_next = sec_reg - SEC_W'(1);
            if (sec_reg == SEC_W'(1)) state_next = scoreReached ? LEVEL_END : GAME_OVER;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      LEVEL_END: begin
        if (startOfFrame) begin
          if (cnt_reg == CNT_W'(SHOW_FRAMES - 1)) begin
            cnt_next = '0;
            if (level_reg == LEVEL_W'(MAX_LEVEL)) begin
              state_next = GAME_OVER;
            end else begin
              state_next = PLAY;
              level_next = level_reg + LEVEL_W'(1);
              sec_next   = SEC_W'(LEVEL_SECONDS);
              pulse_next = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      GAME_OVER: begin
        if (key_edge) begin
          state_next = IDLE;
          level_next = LEVEL_W'(1);
          sec_next   = SEC_W'(LEVEL_SECONDS);
        end
      end
      default: state_next = IDLE;
    endcase
    // Leaving PLAY always unpauses
    if (state_next != PLAY) paused_next = 1'b0;
    case (state_next)
      IDLE:      en_next = 4'b1000;
      PLAY:      en_next = 4'b0100;
      LEVEL_END: en_next = 4'b0010;
      default:   en_next = 4'b0001;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg  <= IDLE;
      level_reg  <= LEVEL_W'(1);
      sec_reg    <= SEC_W'(LEVEL_SECONDS);
      cnt_reg    <= '0;
      pulse_reg  <= 1'b0;
      en_reg     <= 4'b1000;
      key_d_reg  <= 1'b1;
      paused_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      level_reg  <= level_next;
      sec_reg    <= sec_next;
      cnt_reg    <= cnt_next;
      pulse_reg  <= pulse_next;
      en_reg     <= en_next;
      key_d_reg  <= keyStart;
      paused_reg <= paused_next;
    end
  end

  assign startScreenEn   = en_reg[3];
  assign gameLoopEn      = en_reg[2];
  assign levelEndEn      = en_reg[1];
  assign gameOverEn      = en_reg[0];
  assign level           = level_reg;
  assign secondsLeft     = sec_reg;
  assign levelStartPulse = pulse_reg;

  layer_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .BG_RGB     (BG_RGB)
  ) u_merge (
    .clk            (clk),
    .resetN         (resetN),
    .layerDrawReq   (layerDrawReq),
    .layerRGB       (layerRGB),
    .drawingRequest (drawingRequest),
    .RGBout         (RGBout)
  );

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with small timing parameters.
module tb_game_flow_controller;

  localparam int FPS = 4;
  localparam int LS  = 3;
  localparam int SF  = 2;
  localparam int ML  = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        keyStart = 1'b1;
  logic        scoreReached = 1'b0;
  logic [3:0]  layerDrawReq = '0;
  logic [31:0] layerRGB = '0;
  logic        startScreenEn, gameLoopEn, levelEndEn, gameOverEn;
  logic [2:0]  level;
  logic [6:0]  secondsLeft;
  logic        levelStartPulse;
  logic        drawingRequest;
  logic [7:0]  RGBout;

  int checks = 0;
  int passes = 0;

  game_flow_controller #(
    .FRAMES_PER_SEC (FPS),
    .LEVEL_SECONDS  (LS),
    .SHOW_FRAMES    (SF),
    .MAX_LEVEL      (ML),
    .NUM_LAYERS     (4),
    .BG_RGB         (8'h00)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .keyStart        (keyStart),
    .scoreReached    (scoreReached),
    .layerDrawReq    (layerDrawReq),
    .layerRGB        (layerRGB),
    .startScreenEn   (startScreenEn),
    .gameLoopEn      (gameLoopEn),
    .levelEndEn      (levelEndEn),
    .gameOverEn      (gameOverEn),
    .level           (level),
    .secondsLeft     (secondsLeft),
    .levelStartPulse (levelStartPulse),
    .drawingRequest  (drawingRequest),
    .RGBout          (RGBout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [31:0] rgb;
    logic       exp_req;
    logic [7:0] exp_rgb;
  } mv_t;

  mv_t mv [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Enables as {start, loop, levelEnd, gameOver}
  task automatic chk_en(input string name, input logic [3:0] exp);
    chk(name, {28'd0, startScreenEn, gameLoopEn, levelEndEn, gameOverEn}, {28'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic press();
    keyStart = 1'b0;
    tick();
    keyStart = 1'b1;
    tick();
  endtask

  // Twelve frame pulses of a level; final enables depend on the score
  task automatic run_level(input string tag, input logic [3:0] final_en);
    for (int k = 1; k <= 12; k++) begin
      sof();
      chk($sformatf("%s_sec_%0d", tag, k), {25'd0, secondsLeft}, 32'(LS - k / FPS));
      if (k < 12) chk_en($sformatf("%s_en_%0d", tag, k), 4'b0100);
      else        chk_en($sformatf("%s_en_end", tag), final_en);
    end
  endtask

  initial begin
    mv[0] = '{"mux_0110", 4'b0110, 32'h33F0FC11, 1'b1, 8'hFC};
    mv[1] = '{"mux_0000", 4'b0000, 32'h33F0FC11, 1'b0, 8'h00};
    mv[2] = '{"mux_1000", 4'b1000, 32'h33F0FC11, 1'b1, 8'h33};
    mv[3] = '{"mux_0001", 4'b0001, 32'h33F0FC11, 1'b1, 8'h11};
    mv[4] = '{"mux_1111", 4'b1111, 32'h33F0FC11, 1'b1, 8'h11};
    mv[5] = '{"mux_1100", 4'b1100, 32'h33F0FC11, 1'b1, 8'hF0};

    // Reset with the start key held
    #1 resetN = 1'b0;
    #1;
    chk_en("reset_en", 4'b1000);
    chk("reset_level", {29'd0, level}, 32'd1);
    chk("reset_sec", {25'd0, secondsLeft}, 32'(LS));
    chk("reset_pulse", {31'd0, levelStartPulse}, 32'd0);
    chk("reset_dreq", {31'd0, drawingRequest}, 32'd0);
    chk("reset_rgb", {24'd0, RGBout}, 32'h00);
    repeat (2) @(posedge clk);
    #2 resetN = 1'b1;
    repeat (3) tick();
    chk_en("held_key_idle", 4'b1000);

    // Start level 1
    press();
    chk_en("start_play", 4'b0100);
    chk("start_pulse", {31'd0, levelStartPulse}, 32'd1);
    chk("start_level", {29'd0, level}, 32'd1);
    chk("start_sec", {25'd0, secondsLeft}, 32'(LS));
    tick();
    chk("pulse_single", {31'd0, levelStartPulse}, 32'd0);

    scoreReached = 1'b1;
    run_level("l1", 4'b0010);
    sof();
    chk_en("l1_show1", 4'b0010);
    sof();
    chk_en("l2_play", 4'b0100);
    chk("l2_level", {29'd0, level}, 32'd2);
    chk("l2_sec", {25'd0, secondsLeft}, 32'(LS));
    chk("l2_pulse", {31'd0, levelStartPulse}, 32'd1);

    run_level("l2", 4'b0010);
    sof();
    chk_en("l2_show1", 4'b0010);
    sof();
    chk_en("l2_gameover", 4'b0001);
    chk("l2_gameover_level", {29'd0, level}, 32'd2);
    press();
    chk_en("back_idle", 4'b1000);
    chk("back_idle_level", {29'd0, level}, 32'd1);
    chk("back_idle_sec", {25'd0, secondsLeft}, 32'(LS));

    // Timeout without the score: straight to game over; key ignored in play
    press();
    chk_en("g2_play", 4'b0100);
    press();
    chk_en("g2_key_ignored", 4'b0100);
    chk("g2_key_ignored_sec", {25'd0, secondsLeft}, 32'(LS));
    scoreReached = 1'b0;
    run_level("fail", 4'b0001);
    chk("fail_sec0", {25'd0, secondsLeft}, 32'd0);
    sof();
    chk_en("over_hold", 4'b0001);
    chk("over_no_underflow", {25'd0, secondsLeft}, 32'd0);

    // Asynchronous reset mid-level
    press();
    press();
    chk_en("g3_play", 4'b0100);
    layerDrawReq = 4'b0001;
    layerRGB = 32'h00000055;
    scoreReached = 1'b1;
    for (int k = 0; k < 8; k++) sof();
    chk("g3_sec1", {25'd0, secondsLeft}, 32'd1);
    chk("g3_dreq", {31'd0, drawingRequest}, 32'd1);
    resetN = 1'b0;
    #1;
    chk_en("async_en", 4'b1000);
    chk("async_sec", {25'd0, secondsLeft}, 32'(LS));
    chk("async_level", {29'd0, level}, 32'd1);
    chk("async_dreq", {31'd0, drawingRequest}, 32'd0);
    chk("async_rgb", {24'd0, RGBout}, 32'h00);
    @(posedge clk);
    #2 resetN = 1'b1;
    tick();
    chk_en("post_reset_idle", 4'b1000);

    // Layer merge vectors
    for (int i = 0; i < 6; i++) begin
      layerDrawReq = mv[i].req;
      layerRGB = mv[i].rgb;
      tick();
      chk({mv[i].name, "_req"}, {31'd0, drawingRequest}, {31'd0, mv[i].exp_req});
      chk({mv[i].name, "_rgb"}, {24'd0, RGBout}, {24'd0, mv[i].exp_rgb});
    end
    // Output holds until the next edge
    layerDrawReq = 4'b0000;
    #1;
    chk("mux_latency", {24'd0, RGBout}, 32'hF0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
